// File: rtl/hid_status_leds.sv
// LED status/activity indicator for the USB HID host: device type, stretched activity, report count, error blink.
// Optional feature: define HID_LED_RATE_EN to add a reports-per-second output and a rate thermometer on the LEDs.
module hid_status_leds #(
   parameter int CLK_HZ     = 12000000,
   parameter int NUM_LEDS   = 8,
   parameter int STRETCH_MS = 50,
   parameter int DIV_LOG2   = 7,
   parameter int BLINK_MS   = 125,
   parameter int HEART_MS   = 500,
   parameter int HOLD_MS    = 1000
) (
   input  logic                usbclk,
   input  logic                usbrst_n,
   input  logic [1:0]          typ,
   input  logic                report,
   input  logic                conerr,
   output logic [NUM_LEDS-1:0] led,
   output logic                activity,
   output logic [15:0]         report_count,
   output logic [1:0]          state
`ifdef HID_LED_RATE_EN
   ,
   output logic [7:0]          report_rate
`endif
);

   localparam int PRE_MAX = CLK_HZ / 1000 - 1;
   localparam int PRE_W   = $clog2(CLK_HZ / 1000 + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONN = 2'd1,
      S_ERR  = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [PRE_W-1:0]    pre_q, pre_d;
   logic                ms_tick;
   logic [7:0]          stretch_q, stretch_d;
   logic                activity_q, activity_d;
   logic [15:0]         count_q, count_d;
   logic [9:0]          hold_q, hold_d;
   logic [9:0]          bcnt_q, bcnt_d;
   logic                blink_q, blink_d;
   logic [9:0]          hcnt_q, hcnt_d;
   logic                heart_q, heart_d;
   logic [NUM_LEDS-1:0] led_q, led_d;
`ifdef HID_LED_RATE_EN
   logic [9:0]          win_q, win_d;
   logic [7:0]          rcnt_q, rcnt_d;
   logic [7:0]          rate_q, rate_d;
   logic                win_end;
`endif

   always_comb begin
      ms_tick   = (pre_q == PRE_W'(PRE_MAX));
      pre_d     = ms_tick ? '0 : pre_q + 1'b1;
      // A report reload beats a coincident tick decrement.
      stretch_d = stretch_q;
      if (report)
         stretch_d = 8'(STRETCH_MS);
      else if (ms_tick && stretch_q != 8'd0)
         stretch_d = stretch_q - 8'd1;
      activity_d = (stretch_d != 8'd0);
      count_d    = count_q + 16'(report);
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         S_IDLE: begin
            if (conerr)              state_d = S_ERR;
            else if (typ != 2'd0)    state_d = S_CONN;
         end
         S_CONN: begin
            if (conerr)              state_d = S_ERR;
            else if (typ == 2'd0)    state_d = S_IDLE;
         end
         S_ERR: begin
            if (!conerr) begin
               state_d = S_HOLD;
               hold_d  = 10'(HOLD_MS);
            end
         end
         S_HOLD: begin
            if (conerr)                state_d = S_ERR;
            else if (hold_q == 10'd0)  state_d = (typ != 2'd0) ? S_CONN : S_IDLE;
            else if (ms_tick)          hold_d  = hold_q - 10'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bcnt_d  = bcnt_q;
      blink_d = blink_q;
      if (state_d == S_ERR && state_q != S_ERR) begin
         bcnt_d  = '0;
         blink_d = 1'b0;
      end else if ((state_q == S_ERR || state_q == S_HOLD) && ms_tick) begin
         if (bcnt_q == 10'(BLINK_MS - 1)) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
         end else begin
            bcnt_d  = bcnt_q + 10'd1;
         end
      end
      hcnt_d  = hcnt_q;
      heart_d = heart_q;
      if (state_d == S_IDLE && state_q != S_IDLE) begin
         hcnt_d  = '0;
         heart_d = 1'b0;
      end else if (state_q == S_IDLE && ms_tick) begin
         if (hcnt_q == 10'(HEART_MS - 1)) begin
            hcnt_d  = '0;
            heart_d = ~heart_q;
         end else begin
            hcnt_d  = hcnt_q + 10'd1;
         end
      end
   end

`ifdef HID_LED_RATE_EN
   always_comb begin
      win_end = ms_tick && (win_q == 10'd999);
      win_d   = win_q;
      if (ms_tick) win_d = win_end ? 10'd0 : win_q + 10'd1;
      rate_d  = rate_q;
      rcnt_d  = rcnt_q;
      // The report in the window-end cycle belongs to the new window.
      if (win_end) begin
         rate_d = rcnt_q;
         rcnt_d = 8'(report);
      end else if (report && rcnt_q != 8'hFF) begin
         rcnt_d = rcnt_q + 8'd1;
      end
   end
`endif

   always_comb begin
      led_d = '0;
      case (state_q)
         S_IDLE: led_d[0] = heart_q;
         S_CONN: begin
            led_d[1:0] = typ;
            led_d[2]   = activity_q;
            led_d[3]   = count_q[DIV_LOG2];
            for (int i = 4; i < NUM_LEDS; i++) begin
`ifdef HID_LED_RATE_EN
               led_d[i] = ((i - 4) < int'(rate_q[7:4]));
`else
               led_d[i] = ((DIV_LOG2 + i - 3) < 16) ? count_q[4'(DIV_LOG2 + i - 3)] : 1'b0;
`endif
            end
         end
         S_ERR:  led_d = {NUM_LEDS{blink_q}};
         S_HOLD: begin
            led_d    = {NUM_LEDS{blink_q}};
            led_d[0] = 1'b1;
         end
         default: led_d = '0;
      endcase
   end

   always_ff @(posedge usbclk or negedge usbrst_n) begin
      if (!usbrst_n) begin
         state_q    <= S_IDLE;
         pre_q      <= '0;
         stretch_q  <= '0;
         activity_q <= 1'b0;
         count_q    <= '0;
         hold_q     <= '0;
         bcnt_q     <= '0;
         blink_q    <= 1'b0;
         hcnt_q     <= '0;
         heart_q    <= 1'b0;
         led_q      <= '0;
`ifdef HID_LED_RATE_EN
         win_q      <= '0;
         rcnt_q     <= '0;
         rate_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         stretch_q  <= stretch_d;
         activity_q <= activity_d;
         count_q    <= count_d;
         hold_q     <= hold_d;
         bcnt_q     <= bcnt_d;
         blink_q    <= blink_d;
         hcnt_q     <= hcnt_d;
         heart_q    <= heart_d;
         led_q      <= led_d;
`ifdef HID_LED_RATE_EN
         win_q      <= win_d;
         rcnt_q     <= rcnt_d;
         rate_q     <= rate_d;
`endif
      end
   end

   assign led          = led_q;
   assign activity     = activity_q;
   assign report_count = count_q;
   assign state        = state_q;
`ifdef HID_LED_RATE_EN
   assign report_rate  = rate_q;
`endif

endmodule

// File: tb/tb_hid_status_leds.sv
// Self-checking bench for hid_status_leds against a time-based behavioural model (honours HID_LED_RATE_EN).
module tb_hid_status_leds;
   localparam int CLK_HZ     = 10000;
   localparam int NUM_LEDS   = 16;
   localparam int STRETCH_MS = 3;
   localparam int DIV_LOG2   = 7;
   localparam int BLINK_MS   = 2;
   localparam int HEART_MS   = 2;
   localparam int HOLD_MS    = 2;
   localparam int MS         = CLK_HZ / 1000;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [1:0]          typ = 2'd0;
   logic                report = 1'b0;
   logic                conerr = 1'b0;
   logic [NUM_LEDS-1:0] led;
   logic                activity;
   logic [15:0]         report_count;
   logic [1:0]          state;
`ifdef HID_LED_RATE_EN
   logic [7:0]          report_rate;
`endif

   int tests = 0;
   int fails = 0;

   hid_status_leds #(
      .CLK_HZ(CLK_HZ), .NUM_LEDS(NUM_LEDS), .STRETCH_MS(STRETCH_MS), .DIV_LOG2(DIV_LOG2),
      .BLINK_MS(BLINK_MS), .HEART_MS(HEART_MS), .HOLD_MS(HOLD_MS)
   ) dut (
      .usbclk(clk), .usbrst_n(rst_n), .typ(typ), .report(report), .conerr(conerr),
      .led(led), .activity(activity), .report_count(report_count), .state(state)
`ifdef HID_LED_RATE_EN
      , .report_rate(report_rate)
`endif
   );

   always #5 clk = ~clk;

   // Model state: time is measured in clock edges since reset release and ms ticks elapsed.
   int e, ticks, rep_ticks, m_cnt, m_state, hold_entry, err_entry, idle_entry;
   int win_rep, m_rate, m_led;
   bit have_rep, m_act, m_blink, m_heart;

   task automatic model_reset();
      e = 0; ticks = 0; rep_ticks = 0; have_rep = 0; m_cnt = 0; m_state = 0;
      hold_entry = 0; err_entry = 0; idle_entry = 0; m_act = 0; m_blink = 0; m_heart = 0;
      m_led = 0; win_rep = 0; m_rate = 0;
   endtask

   function automatic int led_of(int ty);
      int mask, v, n;
      mask = (1 << NUM_LEDS) - 1;
      case (m_state)
         0: v = int'(m_heart);
         1: begin
            v = ty | (int'(m_act) << 2) | (((m_cnt >> DIV_LOG2) & 1) << 3);
`ifdef HID_LED_RATE_EN
            n = ((m_rate >> 4) < NUM_LEDS - 4) ? (m_rate >> 4) : NUM_LEDS - 4;
            v = v | (((1 << n) - 1) << 4);
`else
            n = DIV_LOG2 + 1;
            v = v | ((m_cnt >> n) << 4);
`endif
         end
         2: v = m_blink ? mask : 0;
         default: v = (m_blink ? mask : 0) | 1;
      endcase
      return v & mask;
   endfunction

   task automatic model_edge();
      int ticks_prev, ns;
      bit tick_now;
      ticks_prev = ticks;
      e++;
      tick_now = (e % MS == 0);
      if (tick_now) ticks++;
      m_led = led_of(int'(typ));
      if (report) begin
         have_rep  = 1;
         rep_ticks = ticks;
         m_cnt     = (m_cnt + 1) % 65536;
      end
      m_act = have_rep && ((ticks - rep_ticks) < STRETCH_MS);
      if (tick_now && (ticks % 1000 == 0)) begin
         m_rate  = (win_rep > 255) ? 255 : win_rep;
         win_rep = report ? 1 : 0;
      end else if (report) begin
         win_rep++;
      end
      ns = m_state;
      case (m_state)
         0: if (conerr) ns = 2; else if (typ != 0) ns = 1;
         1: if (conerr) ns = 2; else if (typ == 0) ns = 0;
         2: if (!conerr) begin ns = 3; hold_entry = ticks; end
         default: if (conerr) ns = 2;
                  else if (ticks_prev - hold_entry >= HOLD_MS) ns = (typ != 0) ? 1 : 0;
      endcase
      if (ns == 2 && m_state != 2) err_entry = ticks;
      if (ns == 0 && m_state != 0) idle_entry = ticks;
      m_state = ns;
      m_blink = (((ticks - err_entry) / BLINK_MS) % 2) == 1;
      m_heart = (((ticks - idle_entry) / HEART_MS) % 2) == 1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      chk("state", 32'(state), 32'(m_state));
      chk("activity", 32'(activity), 32'(m_act));
      chk("report_count", 32'(report_count), 32'(m_cnt));
      chk("led", 32'(led), 32'(m_led));
`ifdef HID_LED_RATE_EN
      chk("report_rate", 32'(report_rate), 32'(m_rate));
`endif
   endtask

   // Called just after a clock edge; asserts reset between edges and releases on the next negedge.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_led", 32'(led), 32'd0);
      chk("rst_activity", 32'(activity), 32'd0);
      chk("rst_count", 32'(report_count), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
`ifdef HID_LED_RATE_EN
      chk("rst_rate", 32'(report_rate), 32'd0);
`endif
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic pulse();
      report = 1'b1;
      cyc();
      report = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      do_reset();
      repeat (60) cyc();
      chk("idle_upper_leds", 32'(led >> 1), 32'd0);

      typ = 2'd1;
      repeat (2) cyc();
      pulse();
      repeat (40) cyc();
      pulse();
      repeat (19) cyc();
      pulse();
      repeat (60) cyc();

      typ = 2'd2;
      cyc();
      chk("typ_change_state", 32'(state), 32'd1);
      typ = 2'd3;
      cyc();
      chk("typ_change_led", 32'(led[1:0]), 32'd3);

      for (int i = 0; i < 400; i++) begin
         report = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 63) == 0) typ = 2'($urandom_range(1, 3));
         cyc();
      end
      report = 1'b0;

      typ = 2'd1;
      do_reset();
      cyc();
      for (int i = 0; i < 128; i++) pulse();
      repeat (2) cyc();
      chk("count_128", 32'(report_count), 32'd128);
      chk("led3_128", 32'(led[3]), 32'd1);

      conerr = 1'b1;
      cyc();
      chk("err_next_cycle", 32'(state), 32'd2);
      cyc();
      chk("err_led_cleared", 32'(led), 32'd0);
      for (int i = 0; i < 50; i++) begin
         report = ($urandom_range(0, 2) == 0);
         cyc();
      end
      report = 1'b0;
      conerr = 1'b0;
      cyc();
      chk("hold_entry", 32'(state), 32'd3);
      repeat (30) cyc();
      chk("hold_exit_conn", 32'(state), 32'd1);

      conerr = 1'b1;
      repeat (10) cyc();
      conerr = 1'b0;
      repeat (8) cyc();
      conerr = 1'b1;
      cyc();
      chk("hold_reerr", 32'(state), 32'd2);
      cyc();
      chk("reerr_led_cleared", 32'(led), 32'd0);
      conerr = 1'b0;
      typ = 2'd0;
      repeat (40) cyc();
      chk("hold_exit_idle", 32'(state), 32'd0);

      typ = 2'd1;
      pulse();
      repeat (5) cyc();
      do_reset();

      for (int i = 0; i < 1500; i++) begin
         report = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 99) == 0) conerr = ~conerr;
         if ($urandom_range(0, 79) == 0) typ = 2'($urandom_range(0, 3));
         cyc();
      end
      report = 1'b0;
      conerr = 1'b0;

`ifdef HID_LED_RATE_EN
      typ = 2'd1;
      do_reset();
      for (int c = 1; c <= 20005; c++) begin
         report = ((c < 9000) && (c % 30 == 1)) || ((c > 10000) && (c <= 10070) && (c % 10 == 5));
         cyc();
         if (c == 10000) chk("rate_255", 32'(report_rate), 32'd255);
      end
      report = 1'b0;
      chk("rate_7", 32'(report_rate), 32'd7);
`endif

      do_reset();
      report = 1'b1;
      repeat (65536) cyc();
      report = 1'b0;
      cyc();
      chk("count_wrap", 32'(report_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
